rank_streamer: RTL and testbench

RANK_STREAMER -- requirements
Module: rank_streamer

---
 rtl/rank_streamer.sv | 99 +++++++++
 tb/tb_rank_streamer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rank_streamer.sv
// rank_streamer: loads 7 scores, sorts ids by score with an odd-even transposition
// sort (one layer per cycle), then streams ids in rank order with a pass/fail count.
module rank_streamer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_score,
  input  logic [2:0] opt,
  input  logic [1:0] a,
  input  logic [2:0] b,
  output logic       out_valid,
  output logic [2:0] out_id,
  output logic [2:0] out_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [2:0] opt_r;
  logic [1:0] a_r;
  logic [2:0] b_r;
  logic signed [4:0] key [7];
  logic signed [4:0] key_s [7];
  logic [2:0] ids [7];
  logic [2:0] ids_s [7];
  logic signed [4:0] val;
  logic sgn;
  logic signed [7:0] sum, avg;
  logic signed [8:0] thr, a1, bb, kk, t;
  logic [2:0] p;
  assign sgn = state == IDLE ? opt[0] : opt_r[0];
  assign val = sgn ? {in_score[3], in_score} : {1'b0, in_score};
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = LOAD;
    else if (state != IDLE && cnt == 3'd6) state_n = state == LOAD ? SORT : state == SORT ? OUT : IDLE;
    cnt_n = state_n != state ? (state_n == LOAD ? 3'd1 : 3'd0) : (state == IDLE ? 3'd0 : cnt + 3'd1);
  end
  // even cycles compare (0,1),(2,3),(4,5); odd cycles (1,2),(3,4),(5,6); strict compare keeps ties in id order
  always_comb begin
    key_s = key;
    ids_s = ids;
    for (int i = 0; i < 6; i++)
      if ((i[0] == cnt[0]) && (opt_r[1] ? key[i] < key[i+1] : key[i] > key[i+1])) begin
        key_s[i] = key[i+1];
        key_s[i+1] = key[i];
        ids_s[i] = ids[i+1];
        ids_s[i+1] = ids[i];
      end
  end
  // pass count is order-independent, so it is derived straight from the held keys
  assign a1 = $signed({6'd0, a_r} + 9'd1);
  assign bb = $signed({6'd0, b_r});
  always_comb begin
    sum = '0;
    for (int i = 0; i < 7; i++) sum = sum + {{3{key[i][4]}}, key[i]};
    avg = sum / 8'sd7;
    thr = $signed({avg[7], avg}) - $signed({7'd0, a_r});
    p = '0;
    kk = '0;
    t = '0;
    for (int i = 0; i < 7; i++) begin
      kk = {{4{key[i][4]}}, key[i]};
      t = kk >= 0 ? kk * a1 + bb : kk / a1 + bb;
      p = p + 3'(t >= thr);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      opt_r <= '0;
      a_r <= '0;
      b_r <= '0;
      for (int i = 0; i < 7; i++) begin
        key[i] <= '0;
        ids[i] <= '0;
      end
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && in_valid) begin
        opt_r <= opt;
        a_r <= a;
        b_r <= b;
        key[0] <= val;
        ids[0] <= 3'd0;
      end else if (state == LOAD) begin
        key[cnt] <= val;
        ids[cnt] <= cnt;
      end else if (state == SORT) begin
        key <= key_s;
        ids <= ids_s;
      end
    end
  end
  assign out_valid = state == OUT;
  assign out_id = out_valid ? ids[cnt] : 3'd0;
  assign out_cnt = out_valid ? (opt_r[2] ? 3'd7 - p : p) : 3'd0;
endmodule

// File: tb/tb_rank_streamer.sv
// tb_rank_streamer: table-driven jobs plus randomized jobs against a rank-counting model,
// with a scoreboard queue consumed whenever out_valid is seen.
module tb_rank_streamer;
  logic clk = 1'b0, rst, in_valid;
  logic [3:0] in_score;
  logic [2:0] opt, b, out_id, out_cnt;
  logic [1:0] a;
  logic out_valid;
  always #5 clk = ~clk;
  rank_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_score(in_score), .opt(opt), .a(a), .b(b),
    .out_valid(out_valid), .out_id(out_id), .out_cnt(out_cnt)
  );
  typedef struct packed {
    logic [2:0] opt;
    logic [1:0] a;
    logic [2:0] b;
    logic [6:0][3:0] sc;
    logic [6:0][2:0] eid;
    logic [2:0] ecnt;
  } job_t;
  typedef struct packed {
    logic [2:0] id;
    logic [2:0] cnt;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  bit mon_on = 1'b0;
  int t_opt [6] = '{0, 2, 6, 1, 5, 3};
  int t_a [6] = '{0, 0, 0, 0, 0, 1};
  int t_sc [6][7] = '{'{0,1,2,3,4,5,6}, '{0,1,2,3,4,5,6}, '{0,1,2,3,4,5,6},
                      '{15,15,15,15,15,15,15}, '{15,15,15,15,15,15,15}, '{8,7,0,0,0,0,0}};
  int t_id [6][7] = '{'{0,1,2,3,4,5,6}, '{6,5,4,3,2,1,0}, '{6,5,4,3,2,1,0},
                      '{0,1,2,3,4,5,6}, '{0,1,2,3,4,5,6}, '{1,2,3,4,5,6,0}};
  int t_cnt [6] = '{4, 4, 3, 7, 0, 6};
  job_t tab [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (mon_on) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected out_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("out_id", 32'(out_id), 32'(e.id));
        check("out_cnt", 32'(out_cnt), 32'(e.cnt));
      end
    end else check("idle outputs zero", {out_valid, out_id, out_cnt}, 0);
  end

  function automatic job_t model(input job_t j);
    int v[7];
    int sum, thr, t, p, av, bv, r;
    sum = 0;
    p = 0;
    av = int'(j.a);
    bv = int'(j.b);
    for (int i = 0; i < 7; i++) begin
      v[i] = j.opt[0] ? int'($signed(j.sc[i])) : int'(j.sc[i]);
      sum += v[i];
    end
    thr = sum / 7 - av;
    for (int i = 0; i < 7; i++) begin
      t = v[i] >= 0 ? v[i] * (av + 1) + bv : v[i] / (av + 1) + bv;
      if (t >= thr) p++;
      r = 0;
      for (int k = 0; k < 7; k++)
        if (j.opt[1] ? (v[k] > v[i] || (v[k] == v[i] && k < i)) : (v[k] < v[i] || (v[k] == v[i] && k < i))) r++;
      j.eid[r] = 3'(i);
    end
    j.ecnt = 3'(j.opt[2] ? 7 - p : p);
    return j;
  endfunction

  task automatic drive(input job_t j);
    for (int r = 0; r < 7; r++) sb.push_back({j.eid[r], j.ecnt});
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_score = j.sc[k];
      opt = k == 0 ? j.opt : 3'($urandom);
      a = k == 0 ? j.a : 2'($urandom);
      b = k == 0 ? j.b : 3'($urandom);
      @(posedge clk) #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input job_t j, input bit noisy);
    drive(j);
    for (int c = 1; c < 7; c++) begin
      in_valid = noisy && c == 3;
      in_score = 4'($urandom);
      @(posedge clk) #1;
    end
    in_valid = 1'b0;
    check("out_valid low at L+7", 32'(out_valid), 0);
    @(posedge clk) #1;
    check("out_valid high at L+8", 32'(out_valid), 1);
    for (int c = 9; c < 15; c++) begin
      in_valid = noisy && c == 10;
      @(posedge clk) #1;
    end
    in_valid = 1'b0;
    @(posedge clk) #1;
    check("out_valid low at L+15", 32'(out_valid), 0);
    check("scoreboard drained", 32'(sb.size()), 0);
  endtask

  initial begin
    job_t j;
    rst = 1'b1;
    in_valid = 1'b0;
    in_score = '0;
    opt = '0;
    a = '0;
    b = '0;
    for (int t = 0; t < 6; t++) begin
      tab[t] = '0;
      tab[t].opt = 3'(t_opt[t]);
      tab[t].a = 2'(t_a[t]);
      for (int k = 0; k < 7; k++) begin
        tab[t].sc[k] = 4'(t_sc[t][k]);
        tab[t].eid[k] = 3'(t_id[t][k]);
      end
      tab[t].ecnt = 3'(t_cnt[t]);
    end
    repeat (2) @(posedge clk) #1;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_id", 32'(out_id), 0);
    check("reset out_cnt", 32'(out_cnt), 0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk) #1;
    for (int t = 0; t < 6; t++) run_job(tab[t], t == 2);
    drive(tab[1]);
    repeat (9) @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    check("abort out_valid", 32'(out_valid), 0);
    check("abort out_id", 32'(out_id), 0);
    check("abort out_cnt", 32'(out_cnt), 0);
    check("abort leftover ids", 32'(sb.size()), 4);
    sb.delete();
    repeat (12) @(posedge clk) #1;
    run_job(tab[0], 1'b0);
    for (int n = 0; n < 12; n++) begin
      j = '0;
      j.opt = 3'($urandom);
      j.a = 2'($urandom);
      j.b = 3'($urandom);
      for (int k = 0; k < 7; k++) j.sc[k] = 4'($urandom_range(0, 3) == 0 ? 4'd7 : $urandom);
      run_job(model(j), n[0]);
      repeat (n % 3) @(posedge clk) #1;
    end
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
